// File: rtl/conv_par_seq.sv
// conv_par_seq: control sequencer for the parallel convolution datapath.
// Waits for both sample memories to fill, locks them, steps the window
// offset across every valid output position, registers each MAC result
// and hands it downstream over a valid/ready handshake. A one-cycle
// conv_done pulse releases the memories for the next frame.
module conv_par_seq #(
  parameter int X_SIZE    = 8,
  parameter int F_SIZE    = 4,
  parameter int ACC_SIZE  = 18,
  parameter int OFS_WIDTH = $clog2(X_SIZE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       xmem_full,
  input  logic                       fmem_full,
  input  logic signed [ACC_SIZE-1:0] mac_result,
  output logic [OFS_WIDTH-1:0]       win_offset,
  output logic                       mem_lock,
  output logic                       conv_done,
  output logic                       m_valid_y,
  input  logic                       m_ready_y,
  output logic signed [ACC_SIZE-1:0] m_data_out_y,
  output logic                       busy
);

  // Number of window positions that fit entirely inside X memory.
  localparam int N_OUT = X_SIZE - F_SIZE + 1;
  localparam logic [OFS_WIDTH-1:0] LAST_OFS = OFS_WIDTH'(N_OUT - 1);
  localparam logic [OFS_WIDTH-1:0] OFS_ONE  = OFS_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    LOAD = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state;
  state_t state_next;
  logic   handshake;
  logic   last_window;

  // Valid is decoded from SEND, so a transfer is simply SEND with ready high.
  assign handshake   = (state == SEND) && m_ready_y;
  assign last_window = (win_offset == LAST_OFS);

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and Moore outputs taken from the registered state only.
  always_comb begin
    state_next = state;
    mem_lock   = 1'b0;
    conv_done  = 1'b0;
    m_valid_y  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (xmem_full && fmem_full) begin
          state_next = ARM;
        end
      end
      ARM: begin
        mem_lock   = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        mem_lock   = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        mem_lock  = 1'b1;
        m_valid_y = 1'b1;
        if (handshake) begin
          state_next = last_window ? DONE : LOAD;
        end
      end
      DONE: begin
        mem_lock   = 1'b1;
        conv_done  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Window offset: cleared when a frame arms or finishes, advanced on each
  // accepted output except the last so it never wraps past the final window.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_offset <= '0;
    end else begin
      case (state)
        ARM, DONE: win_offset <= '0;
        SEND: begin
          if (handshake && !last_window) begin
            win_offset <= win_offset + OFS_ONE;
          end
        end
        default: win_offset <= win_offset;
      endcase
    end
  end

  // Output register: the MAC result has settled for the current offset by
  // the end of LOAD, and is then held unchanged through any backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_data_out_y <= '0;
    end else if (state == LOAD) begin
      m_data_out_y <= mac_result;
    end
  end

endmodule

// File: tb/tb_conv_par_seq.sv
// tb_conv_par_seq: random and directed stimulus for conv_par_seq, checked
// every cycle against a frame-level behavioural model of the sequencer.
module tb_conv_par_seq;

  localparam int X_SIZE    = 8;
  localparam int F_SIZE    = 4;
  localparam int ACC_SIZE  = 18;
  localparam int OFS_WIDTH = $clog2(X_SIZE);
  localparam int N_OUT     = X_SIZE - F_SIZE + 1;

  logic                       clk;
  logic                       reset;
  logic                       xmem_full;
  logic                       fmem_full;
  logic signed [ACC_SIZE-1:0] mac_result;
  logic [OFS_WIDTH-1:0]       win_offset;
  logic                       mem_lock;
  logic                       conv_done;
  logic                       m_valid_y;
  logic                       m_ready_y;
  logic signed [ACC_SIZE-1:0] m_data_out_y;
  logic                       busy;

  conv_par_seq #(
    .X_SIZE(X_SIZE),
    .F_SIZE(F_SIZE),
    .ACC_SIZE(ACC_SIZE),
    .OFS_WIDTH(OFS_WIDTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .xmem_full(xmem_full),
    .fmem_full(fmem_full),
    .mac_result(mac_result),
    .win_offset(win_offset),
    .mem_lock(mem_lock),
    .conv_done(conv_done),
    .m_valid_y(m_valid_y),
    .m_ready_y(m_ready_y),
    .m_data_out_y(m_data_out_y),
    .busy(busy)
  );

  // Memory contents seen by the modelled datapath.
  int x_mem [X_SIZE];
  int f_mem [F_SIZE];
  int mac_sum;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;
  int cap_q[$];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational datapath stand-in: multipliers plus adder tree at win_offset.
  always_comb begin
    mac_sum = 0;
    for (int k = 0; k < F_SIZE; k++) begin
      if (int'(win_offset) + k < X_SIZE) begin
        mac_sum = mac_sum + x_mem[int'(win_offset) + k] * f_mem[k];
      end
    end
    mac_result = mac_sum[ACC_SIZE-1:0];
  end

  function automatic int conv_ref(input int ofs);
    int s;
    s = 0;
    for (int k = 0; k < F_SIZE; k++) begin
      s = s + x_mem[ofs + k] * f_mem[k];
    end
    return s;
  endfunction

  // Frame-level reference: a frame starts when both flags are seen in idle,
  // the first result is offered two cycles after the arm cycle, every
  // accepted result is followed by a blank cycle before the next, and the
  // frame closes with a single done cycle.
  bit md_active = 1'b0;
  bit md_valid  = 1'b0;
  bit md_done   = 1'b0;
  int md_ofs    = 0;
  int md_wait   = 0;
  int exp_y [N_OUT];

  // Model update on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    if (reset) begin
      md_active <= 1'b0;
      md_valid  <= 1'b0;
      md_done   <= 1'b0;
      md_ofs    <= 0;
      md_wait   <= 0;
    end else if (md_done) begin
      md_done   <= 1'b0;
      md_active <= 1'b0;
      md_ofs    <= 0;
    end else if (!md_active) begin
      if (xmem_full && fmem_full) begin
        md_active <= 1'b1;
        md_ofs    <= 0;
        md_wait   <= 2;
        for (int o = 0; o < N_OUT; o++) begin
          exp_y[o] <= conv_ref(o);
        end
      end
    end else if (md_valid) begin
      if (m_ready_y) begin
        md_valid <= 1'b0;
        if (md_ofs == N_OUT - 1) begin
          md_done <= 1'b1;
        end else begin
          md_ofs  <= md_ofs + 1;
          md_wait <= 1;
        end
      end
    end else begin
      md_wait  <= md_wait - 1;
      md_valid <= (md_wait == 1);
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("busy", int'(busy), int'(md_active));
      checkOutput("mem_lock", int'(mem_lock), int'(md_active));
      checkOutput("conv_done", int'(conv_done), int'(md_done));
      checkOutput("m_valid_y", int'(m_valid_y), int'(md_valid));
      checkOutput("win_offset", int'(win_offset), md_active ? md_ofs : 0);
      if (md_valid) begin
        checkOutput("m_data_out_y", int'(m_data_out_y), exp_y[md_ofs]);
      end
    end
  end

  task automatic applyStimulus(input bit xf, input bit ff);
    @(negedge clk);
    xmem_full = xf;
    fmem_full = ff;
  endtask

  // Drives ready until conv_done; mode 0 = always ready, 1 = random,
  // 2 = ready held low for 5 cycles while output index 1 is offered.
  task automatic runToDone(input int mode, input bit drop_early,
                           output int done_cyc, output int first_valid);
    int bp_left;
    bit bp_used;
    bp_left     = 0;
    bp_used     = 1'b0;
    done_cyc    = -1;
    first_valid = -1;
    cap_q.delete();
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (drop_early && i == 2) begin
        xmem_full = 1'b0;
        fmem_full = 1'b0;
      end
      if (first_valid < 0 && m_valid_y) first_valid = i;
      if (conv_done) begin
        done_cyc  = i;
        xmem_full = 1'b0;
        fmem_full = 1'b0;
        break;
      end
      if (mode == 2 && m_valid_y && win_offset == 1 && !bp_used) begin
        bp_used = 1'b1;
        bp_left = 5;
      end
      if (bp_left > 0) begin
        m_ready_y = 1'b0;
        bp_left--;
        if (bp_left == 0) begin
          checkOutput("bp_hold_data", int'(m_data_out_y), 14);
          checkOutput("bp_hold_ofs", int'(win_offset), 1);
        end
      end else if (mode == 1) begin
        m_ready_y = ($urandom_range(0, 9) < 6);
      end else begin
        m_ready_y = 1'b1;
      end
      if (m_valid_y && m_ready_y) cap_q.push_back(int'(m_data_out_y));
    end
    if (done_cyc < 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL frame_timeout: conv_done not seen within 400 cycles");
    end
  endtask

  task automatic checkCaptured(input string name, input int exp [N_OUT]);
    checkOutput({name, "_count"}, cap_q.size(), N_OUT);
    for (int k = 0; k < N_OUT; k++) begin
      checkOutput(name, (k < cap_q.size()) ? cap_q[k] : -1, exp[k]);
    end
  endtask

  int ramp_y [N_OUT] = '{10, 14, 18, 22, 26};
  int neg_y  [N_OUT] = '{65536, 65536, 65536, 65536, 65536};
  int mix_y  [N_OUT] = '{-65024, -65024, -65024, -65024, -65024};
  int done_cyc;
  int first_valid;
  int pulses;
  bit found;

  initial begin
    reset     = 1'b1;
    xmem_full = 1'b0;
    fmem_full = 1'b0;
    m_ready_y = 1'b0;
    for (int i = 0; i < X_SIZE; i++) x_mem[i] = i + 1;
    for (int k = 0; k < F_SIZE; k++) f_mem[k] = 1;

    repeat (3) @(negedge clk);
    check_en = 1'b1;
    checkOutput("reset_data", int'(m_data_out_y), 0);
    checkOutput("reset_busy", int'(busy), 0);
    reset = 1'b0;

    // Ramp frame with ready held high.
    $display("[TB] ramp frame");
    applyStimulus(1'b1, 1'b1);
    runToDone(0, 1'b0, done_cyc, first_valid);
    checkOutput("ramp_done_cycle", done_cyc, 2 + 2 * N_OUT);
    checkOutput("ramp_first_valid", first_valid, 3);
    checkCaptured("ramp_y", ramp_y);

    // Back-to-back refill with backpressure on the second output.
    $display("[TB] back-to-back frame with backpressure");
    applyStimulus(1'b1, 1'b1);
    runToDone(2, 1'b0, done_cyc, first_valid);
    checkCaptured("bp_y", ramp_y);

    // Flags low: the sequencer must not restart on its own.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (conv_done || busy) pulses++;
    end
    checkOutput("no_restart", pulses, 0);

    // Signed extremes.
    $display("[TB] signed extremes");
    for (int i = 0; i < X_SIZE; i++) x_mem[i] = -128;
    for (int k = 0; k < F_SIZE; k++) f_mem[k] = -128;
    applyStimulus(1'b1, 1'b1);
    runToDone(1, 1'b0, done_cyc, first_valid);
    checkCaptured("neg_neg_y", neg_y);
    for (int k = 0; k < F_SIZE; k++) f_mem[k] = 127;
    applyStimulus(1'b1, 1'b1);
    runToDone(1, 1'b1, done_cyc, first_valid);
    checkCaptured("neg_pos_y", mix_y);

    // Partial fill keeps the sequencer idle.
    $display("[TB] partial fill");
    for (int i = 0; i < X_SIZE; i++) x_mem[i] = i + 1;
    for (int k = 0; k < F_SIZE; k++) f_mem[k] = 1;
    applyStimulus(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("partial_busy", int'(busy), 0);
    checkOutput("partial_valid", int'(m_valid_y), 0);
    fmem_full = 1'b1;
    @(negedge clk);
    checkOutput("partial_arm_busy", int'(busy), 1);
    checkOutput("partial_arm_lock", int'(mem_lock), 1);
    runToDone(0, 1'b0, done_cyc, first_valid);
    checkOutput("partial_count", cap_q.size(), N_OUT);

    // Reset while the third output is being offered.
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      m_ready_y = 1'b1;
      if (m_valid_y && win_offset == 2) begin
        reset     = 1'b1;
        xmem_full = 1'b0;
        fmem_full = 1'b0;
        found     = 1'b1;
        break;
      end
    end
    checkOutput("reset_mid_reached", int'(found), 1);
    @(negedge clk);
    checkOutput("rmid_valid", int'(m_valid_y), 0);
    checkOutput("rmid_busy", int'(busy), 0);
    checkOutput("rmid_lock", int'(mem_lock), 0);
    checkOutput("rmid_done", int'(conv_done), 0);
    checkOutput("rmid_ofs", int'(win_offset), 0);
    checkOutput("rmid_data", int'(m_data_out_y), 0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1);
    runToDone(0, 1'b0, done_cyc, first_valid);
    checkCaptured("restart_y", ramp_y);

    // Random frames with random ready.
    $display("[TB] random frames");
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < X_SIZE; i++) x_mem[i] = int'($urandom_range(0, 255)) - 128;
      for (int k = 0; k < F_SIZE; k++) f_mem[k] = int'($urandom_range(0, 255)) - 128;
      applyStimulus(1'b1, 1'b1);
      runToDone(1, bit'($urandom_range(0, 1)), done_cyc, first_valid);
      checkOutput("rand_count", cap_q.size(), N_OUT);
      checkOutput("rand_first_valid", first_valid, 3);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
